// File: rtl/plugin_arith_pkg.sv
// ============================================================================
// plugin_arith_pkg : shared opcode and FSM state types for plugin_arith
// Revision: 1.0
// ============================================================================
`default_nettype none

package plugin_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDC = 2'b01,
        OP_SUB  = 2'b10,
        OP_MAXU = 2'b11
    } plugin_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_EXECUTE = 2'b10,
        ST_FINISH  = 2'b11
    } plugin_state_t;

endpackage

`default_nettype wire

// File: rtl/plugin_arith_if.sv
// ============================================================================
// plugin_arith_if : start/busy/done request bus between core and plugin
// Revision: 1.0
// ============================================================================
`default_nettype none

interface plugin_arith_if #(
    parameter int DATA_WIDTH = 32
) ();
    import plugin_arith_pkg::*;

    logic                  start;
    plugin_op_t            op;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  abort;
    logic [DATA_WIDTH-1:0] result;
    logic                  flag;
    logic                  busy;
    logic                  done;

    modport master (
        output start, op, operand_a, operand_b, abort,
        input  result, flag, busy, done
    );

    modport slave (
        input  start, op, operand_a, operand_b, abort,
        output result, flag, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/plugin_arith_core.sv
// ============================================================================
// plugin_arith_core : combinational ADD/ADDC/SUB/MAXU datapath with flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module plugin_arith_core
    import plugin_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_CONST  = 5
) (
    input  plugin_op_t            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  flag_o
);

    localparam int                    XW    = DATA_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] C_KON = DATA_WIDTH'(ADD_CONST);

    logic [XW-1:0] w_a;
    logic [XW-1:0] w_b;
    logic [XW-1:0] w_sum;

    assign w_a = {2'b00, a_i};
    assign w_b = {2'b00, b_i};

    // Two guard bits: ADDC can exceed 2^W by more than one carry, and SUB
    // wraps so that the top guard bit acts as the borrow.
    always_comb begin
        w_sum  = '0;
        res_o  = '0;
        flag_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                w_sum  = w_a + w_b;
                res_o  = w_sum[DATA_WIDTH-1:0];
                flag_o = |w_sum[XW-1:DATA_WIDTH];
            end
            OP_ADDC: begin
                w_sum  = w_a + w_b + {2'b00, C_KON};
                res_o  = w_sum[DATA_WIDTH-1:0];
                flag_o = |w_sum[XW-1:DATA_WIDTH];
            end
            OP_SUB: begin
                w_sum  = w_a - w_b;
                res_o  = w_sum[DATA_WIDTH-1:0];
                flag_o = w_sum[XW-1];
            end
            default: begin
                flag_o = (a_i < b_i);
                res_o  = flag_o ? b_i : a_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/plugin_arith.sv
// ============================================================================
// plugin_arith : multi-cycle arithmetic plugin with abort and configurable latency
// Revision: 1.0
// ============================================================================
`default_nettype none

module plugin_arith
    import plugin_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1,
    parameter int ADD_CONST  = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    plugin_arith_if.slave  bus
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("plugin_arith: LATENCY must be >= 1");
    end
    if (DATA_WIDTH < 8) begin : g_bad_width
        $error("plugin_arith: DATA_WIDTH must be >= 8");
    end

    plugin_state_t         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    plugin_op_t            op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [DATA_WIDTH-1:0] res_q, result_q;
    logic                  flag_q, rflag_q;

    logic [DATA_WIDTH-1:0] w_core_res;
    logic                  w_core_flag;
    logic                  w_accept;
    logic                  w_commit;

    plugin_arith_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADD_CONST  (ADD_CONST)
    ) u_core (
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .res_o  (w_core_res),
        .flag_o (w_core_flag)
    );

    assign w_accept = (state_q == ST_IDLE) && bus.start;
    assign w_commit = (state_q == ST_EXECUTE) && !bus.abort && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXECUTE;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            ST_EXECUTE: begin
                // Abort wins over completion so a flushed op never reports.
                if (bus.abort)          state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_FINISH;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            flag_q   <= 1'b0;
            result_q <= '0;
            rflag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                op_q <= bus.op;
                a_q  <= bus.operand_a;
                b_q  <= bus.operand_b;
            end
            if (state_q == ST_LOAD) begin
                res_q  <= w_core_res;
                flag_q <= w_core_flag;
            end
            if (w_commit) begin
                result_q <= res_q;
                rflag_q  <= flag_q;
            end
        end
    end

    assign bus.busy   = (state_q == ST_LOAD) || (state_q == ST_EXECUTE);
    assign bus.done   = (state_q == ST_FINISH);
    assign bus.result = result_q;
    assign bus.flag   = rflag_q;

endmodule

`default_nettype wire
